// File: rtl/opamp_sched_pkg.sv
// rtl/opamp_sched_pkg.sv - state encoding, default widths and index-width helper for opamp_channel_sched
package opamp_sched_pkg;

  localparam int DEF_N_REQ    = 4;
  localparam int DEF_DATA_W   = 12;
  localparam int DEF_SETTLE_W = 8;
  localparam int DEF_TMO_CYC  = 255;

  typedef enum logic [2:0] {
    IDLE,
    GRANT,
    SETTLE,
    SAMPLE,
    WAIT_ADC,
    RESP
  } state_t;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/opamp_rr_arbiter.sv
// rtl/opamp_rr_arbiter.sv - combinational round-robin arbiter; search begins at index start
module opamp_rr_arbiter
  import opamp_sched_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]        req,
  input  logic [idx_w(N_REQ)-1:0] start,
  output logic [N_REQ-1:0]        gnt,
  output logic [idx_w(N_REQ)-1:0] idx,
  output logic                    any_req
);

  localparam int IW = idx_w(N_REQ);

  always_comb begin : rr_search
    int j;
    j       = 0;
    gnt     = '0;
    idx     = '0;
    any_req = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      j = int'(start) + i;
      if (j >= N_REQ) j = j - N_REQ;
      if (!any_req && req[j]) begin
        any_req = 1'b1;
        gnt[j]  = 1'b1;
        idx     = IW'(j);
      end
    end
  end

endmodule

// File: rtl/opamp_channel_sched.sv
// rtl/opamp_channel_sched.sv - op-amp channel time-multiplex scheduler; ADC watchdog under OPAMP_SCHED_TIMEOUT_EN
module opamp_channel_sched
  import opamp_sched_pkg::*;
#(
  parameter int N_REQ    = DEF_N_REQ,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int SETTLE_W = DEF_SETTLE_W,
  parameter int TMO_CYC  = DEF_TMO_CYC
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_REQ-1:0]        req,
  input  logic [SETTLE_W-1:0]     settle_cyc,
  output logic [idx_w(N_REQ)-1:0] mux_sel,
  output logic                    amp_en,
  output logic                    adc_start,
  input  logic                    adc_valid,
  input  logic [DATA_W-1:0]       adc_data,
  output logic [N_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]       rsp_data,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int IW = idx_w(N_REQ);

  state_t              state, state_nx;
  logic [IW-1:0]       win_q, rr_ptr, arb_start, arb_idx;
  logic [N_REQ-1:0]    win_oh_q, arb_gnt;
  logic                arb_any;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [DATA_W-1:0]   data_q;
  logic                tmo_hit;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] i);
    return (int'(i) == N_REQ - 1) ? '0 : i + 1'b1;
  endfunction

  // In RESP the pointer is being advanced this very cycle, so arbitrate from its next value.
  assign arb_start = (state == RESP) ? wrap_inc(win_q) : rr_ptr;

  opamp_rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .req    (req),
    .start  (arb_start),
    .gnt    (arb_gnt),
    .idx    (arb_idx),
    .any_req(arb_any)
  );

`ifdef OPAMP_SCHED_TIMEOUT_EN
  localparam int TW = $clog2(TMO_CYC + 1);
  logic [TW-1:0] tmo_cnt;
  logic          err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      tmo_cnt <= (state == WAIT_ADC) ? tmo_cnt + 1'b1 : '0;
      if (state == WAIT_ADC) begin
        if (adc_valid)    err_q <= 1'b0;
        else if (tmo_hit) err_q <= 1'b1;
      end
    end
  end

  assign tmo_hit = (state == WAIT_ADC) && (tmo_cnt == TW'(TMO_CYC - 1));
`else
  logic unused_tmo;
  assign unused_tmo = (TMO_CYC > 0);
  assign tmo_hit    = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      win_q      <= '0;
      win_oh_q   <= '0;
      rr_ptr     <= '0;
      settle_cnt <= '0;
      data_q     <= '0;
    end else begin
      state <= state_nx;
      // Winner is registered on entry to GRANT so mux_sel is already valid during GRANT.
      if (state_nx == GRANT) begin
        win_q    <= arb_idx;
        win_oh_q <= arb_gnt;
      end
      case (state)
        GRANT:    settle_cnt <= settle_cyc;
        SETTLE:   settle_cnt <= settle_cnt - 1'b1;
        WAIT_ADC: begin
          if (adc_valid)    data_q <= adc_data;
          else if (tmo_hit) data_q <= '0;
        end
        RESP:     rr_ptr <= wrap_inc(win_q);
        default:  ;
      endcase
    end
  end

  always_comb begin
    state_nx  = state;
    busy      = (state != IDLE);
    amp_en    = (state != IDLE);
    adc_start = (state == SAMPLE);
    rsp_valid = (state == RESP) ? win_oh_q : '0;
    rsp_err   = 1'b0;
`ifdef OPAMP_SCHED_TIMEOUT_EN
    rsp_err   = (state == RESP) && err_q;
`endif
    case (state)
      IDLE:     if (arb_any) state_nx = GRANT;
      GRANT:    state_nx = (settle_cyc == '0) ? SAMPLE : SETTLE;
      SETTLE:   if (settle_cnt <= SETTLE_W'(1)) state_nx = SAMPLE;
      SAMPLE:   state_nx = WAIT_ADC;
      WAIT_ADC: if (adc_valid || tmo_hit) state_nx = RESP;
      RESP:     state_nx = arb_any ? GRANT : IDLE;
      default:  state_nx = IDLE;
    endcase
  end

  assign mux_sel  = win_q;
  assign rsp_data = data_q;

endmodule

// File: doc/opamp_channel_sched.md
Name: opamp_channel_sched

Overview:
- Time-multiplexes one op-amp buffer/filter channel (VCVS gain stage plus RC low-pass) between N digital requesters.
- Per grant: steers the input mux, enables the amplifier, waits a programmed settling time of several RC time constants, strobes the downstream ADC, and returns the sample to the winning requester.
- Sits between requester agents and the analog front-end macro; the only owner of amp_en and mux_sel.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- DATA_W, 12, ADC sample width.
- SETTLE_W, 8, width of the settle-count configuration input.
- TMO_CYC, 255, ADC watchdog limit in cycles (used only with the optional feature).

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- req  in  N_REQ  level request per requester; held until its rsp_valid.
- settle_cyc  in  SETTLE_W  settle wait in cycles; sampled at grant time.
- mux_sel  out  $clog2(N_REQ)  analog input mux select.
- amp_en  out  1  amplifier enable.
- adc_start  out  1  one-cycle ADC conversion strobe.
- adc_valid  in  1  ADC result valid (one cycle).
- adc_data  in  DATA_W  ADC result.
- rsp_valid  out  N_REQ  one-hot, one-cycle response strobe.
- rsp_data  out  DATA_W  sample; valid with rsp_valid.
- rsp_err  out  1  response carries a timeout error (optional feature only; otherwise tied 0).
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset values: all outputs 0, state IDLE, round-robin pointer 0, counters 0. Reset asserted mid-operation aborts immediately: amp_en drops asynchronously and no response is issued.
- States and transitions:
  - IDLE: if any req is set, go to GRANT.
  - GRANT (1 cycle): round-robin arbitration. Search starts at the index after the last winner. Latch winner index into mux_sel. Latch settle_cyc. amp_en set to 1. Go to SETTLE.
  - SETTLE: count down the latched settle_cyc value. settle_cyc=0 means go directly to SAMPLE on the next cycle.
  - SAMPLE (1 cycle): adc_start=1. Go to WAIT_ADC.
  - WAIT_ADC: on adc_valid, capture adc_data. Go to RESP.
  - RESP (1 cycle): rsp_valid[winner]=1 and rsp_data driven. Update the pointer to the winner. If any req is still set, go to GRANT; else go to IDLE.
- Amplifier and mux control:
  - amp_en is 1 from GRANT through RESP.
  - On back-to-back grants amp_en stays 1. The settle wait is always reapplied after a mux change.
- Timing:
  - mux_sel changes only in GRANT. It is stable from GRANT through RESP.
  - Latency from req rising, with the block idle, to rsp_valid = 1 (IDLE) + 1 (GRANT) + settle_cyc + 1 (SAMPLE) + ADC latency + 1 (RESP).
- Request behaviour:
  - A req dropping after its grant is ignored; the transaction completes and the response is still issued.
  - A req bit that remains set after its response is re-arbitrated normally. Round robin guarantees no starvation: worst-case wait is N_REQ-1 transactions.
- adc_valid outside WAIT_ADC is ignored. rsp_data holds its last value between responses.

Optional Feature:
- Macro OPAMP_SCHED_TIMEOUT_EN.
- Defined: a counter runs in WAIT_ADC. Reaching TMO_CYC forces RESP with rsp_data=0 and rsp_err=1. If adc_valid arrives in the same cycle as the timeout, the data wins and rsp_err=0.
- Undefined: WAIT_ADC waits indefinitely and rsp_err is tied to 0.

Decomposition:
- Package opamp_sched_pkg holds:
  - the state enum (IDLE, GRANT, SETTLE, SAMPLE, WAIT_ADC, RESP);
  - default widths;
  - the index-width function.
- Sub-module opamp_rr_arbiter:
  - Inputs: req vector and last-winner pointer.
  - Outputs: one-hot grant, encoded index and any_req.
  - Purely combinational. Instantiated once.

Test Plan:
- Single request: req=0001, settle_cyc=3, ADC returns 0xABC after 2 cycles -> mux_sel=0, amp_en high 8 cycles, rsp_valid=0001 with 0xABC, 9 cycles after req rises.
- Contention: req=1111 held -> grant order 0,1,2,3,0. amp_en never drops. One adc_start per transaction.
- settle_cyc=0 -> adc_start in the cycle after GRANT.
- Reset asserted in WAIT_ADC -> amp_en, busy and adc_start are 0 immediately, with no rsp_valid. After release, pending req restarts from pointer 0.
- With OPAMP_SCHED_TIMEOUT_EN and TMO_CYC=10, no adc_valid -> rsp_valid with rsp_err=1 and rsp_data=0. A same-cycle adc_valid yields rsp_err=0.
- A stray adc_valid in IDLE/SETTLE -> ignored; the next response carries the correct in-window sample.
